csoc_cmd_proc: RTL and testbench

Command processor on the part-tester side of the CSoC UART link. Consumes bytes from `uart_rx` and decodes the single-letter command set: r, s, g, e, i, o, f, d. Drives the part's clock, reset, scan and primary-input pins, and returns ASCII '0'/'1' responses through `uart_tx`. It is the responder to the host-side command sequences (set/get state, set inputs/get outputs, execute, free run).

---
 rtl/csoc_cmd_proc.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_csoc_cmd_proc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/csoc_cmd_proc.sv
// csoc_cmd_proc: part-tester side of the CSoC UART link. Decodes single-letter
// commands from the byte receiver, drives the part's clock/reset/scan/PI pins
// and answers with ASCII bytes through a ready/start transmit handshake.
module csoc_cmd_proc #(
  parameter int PI_W       = 8,
  parameter int PO_W       = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rx_rcv,
  input  logic [7:0]      rx_data,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic            part_clk,
  output logic            part_rstn,
  output logic            part_se,
  output logic            part_tm,
  output logic            part_si,
  input  logic            part_so,
  output logic [PI_W-1:0] part_pi,
  input  logic [PO_W-1:0] part_po,
  output logic            busy
);

  // Encoding is visible to benches that poll the state, so it is pinned.
  typedef enum logic [3:0] {
    INIT   = 4'd0,
    CNT_HI = 4'd1,
    CNT_LO = 4'd2,
    SETBIT = 4'd3,
    GETBIT = 4'd4,
    IDLE   = 4'd5,
    EXEC   = 4'd6,
    FREE   = 4'd7,
    PRST   = 4'd8,
    TXWAIT = 4'd9,
    SHIFT  = 4'd10
  } state_t;

  localparam logic [7:0] CH_R = 8'h72;
  localparam logic [7:0] CH_S = 8'h73;
  localparam logic [7:0] CH_G = 8'h67;
  localparam logic [7:0] CH_E = 8'h65;
  localparam logic [7:0] CH_I = 8'h69;
  localparam logic [7:0] CH_O = 8'h6F;
  localparam logic [7:0] CH_F = 8'h66;
  localparam logic [7:0] CH_D = 8'h64;
  localparam logic [7:0] CH_0 = 8'h30;
  localparam logic [7:0] CH_1 = 8'h31;
  localparam logic [7:0] CH_Q = 8'h3F;
  localparam logic [7:0] CH_X = 8'h21;

  state_t          state, state_n, ret, ret_n;
  logic [7:0]      cmd, cmd_n;
  logic [15:0]     cnt, cnt_n;
  logic [15:0]     idx, idx_n;
  logic            flag, flag_n;     // FREE: stop requested; SHIFT: high half done
  logic [PO_W-1:0] po_snap, po_snap_n;

  logic            tx_start_n;
  logic [7:0]      tx_data_n;
  logic            part_clk_n, part_rstn_n, part_se_n, part_tm_n, part_si_n;
  logic [PI_W-1:0] part_pi_n;

  logic            rx_is_bit;
  logic [15:0]     cnt_rx;
  logic            last;
  logic            po_bit;
  logic            get_bit;

  assign rx_is_bit = (rx_data == CH_0) || (rx_data == CH_1);
  assign cnt_rx    = {cnt[15:8], rx_data};
  assign last      = ((idx + 16'd1) == cnt);
  assign busy      = (state != IDLE);
  assign get_bit   = (cmd == CH_G) ? part_so : po_bit;

  // Pick the snapshotted output bit addressed by idx; bits past PO_W read 0
  always_comb begin
    po_bit = 1'b0;
    for (int b = 0; b < PO_W; b++)
      if (idx == 16'(b)) po_bit = po_snap[b];
  end

  // Next-state and next-output decode
  always_comb begin
    state_n     = state;
    ret_n       = ret;
    cmd_n       = cmd;
    cnt_n       = cnt;
    idx_n       = idx;
    flag_n      = flag;
    po_snap_n   = po_snap;
    tx_start_n  = tx_start;
    tx_data_n   = tx_data;
    part_clk_n  = part_clk;
    part_rstn_n = part_rstn;
    part_se_n   = part_se;
    part_tm_n   = part_tm;
    part_si_n   = part_si;
    part_pi_n   = part_pi;

    case (state)
      INIT: begin
        // PRST is entered with the clock already high so the first part
        // cycle starts on this edge.
        state_n     = PRST;
        part_clk_n  = 1'b1;
        part_rstn_n = 1'b0;
        idx_n       = '0;
      end

      PRST: begin
        if (part_clk) begin
          part_clk_n = 1'b0;
          idx_n      = idx + 16'd1;
        end else if (idx == 16'(RST_CYCLES)) begin
          state_n     = IDLE;
          part_rstn_n = 1'b1;
        end else begin
          part_clk_n = 1'b1;
        end
      end

      IDLE: begin
        if (rx_rcv) begin
          case (rx_data)
            CH_R: begin
              state_n     = PRST;
              part_clk_n  = 1'b1;
              part_rstn_n = 1'b0;
              part_se_n   = 1'b0;
              part_tm_n   = 1'b0;
              idx_n       = '0;
            end
            CH_S, CH_G, CH_E, CH_I, CH_O: begin
              cmd_n   = rx_data;
              state_n = CNT_HI;
            end
            CH_F: begin
              state_n   = FREE;
              part_se_n = 1'b0;
              part_tm_n = 1'b0;
              flag_n    = 1'b0;
            end
            CH_D: ;
            default: begin
              tx_data_n  = CH_Q;
              tx_start_n = 1'b1;
              ret_n      = IDLE;
              state_n    = TXWAIT;
            end
          endcase
        end
      end

      CNT_HI: begin
        if (rx_rcv) begin
          cnt_n[15:8] = rx_data;
          state_n     = CNT_LO;
        end
      end

      CNT_LO: begin
        if (rx_rcv) begin
          cnt_n = cnt_rx;
          idx_n = '0;
          if (cnt_rx == 16'd0) begin
            state_n = IDLE;
          end else begin
            case (cmd)
              CH_E, CH_S: state_n = SETBIT;
              CH_G:       state_n = GETBIT;
              CH_I: begin
                po_snap_n = part_po;
                state_n   = GETBIT;
              end
              CH_O: begin
                part_se_n = 1'b0;
                part_tm_n = 1'b0;
                state_n   = EXEC;
              end
              default:    state_n = IDLE;
            endcase
          end
        end
      end

      SETBIT: begin
        if (rx_rcv) begin
          if (!rx_is_bit) begin
            tx_data_n  = CH_X;
            tx_start_n = 1'b1;
            ret_n      = IDLE;
            state_n    = TXWAIT;
          end else if (cmd == CH_E) begin
            for (int b = 0; b < PI_W; b++)
              if (idx == 16'(b)) part_pi_n[b] = rx_data[0];
            idx_n = idx + 16'd1;
            if (last) state_n = IDLE;
          end else begin
            part_si_n = rx_data[0];
            part_se_n = 1'b1;
            part_tm_n = 1'b1;
            flag_n    = 1'b0;
            state_n   = SHIFT;
          end
        end
      end

      GETBIT: begin
        tx_data_n  = {7'b0011000, get_bit};
        tx_start_n = 1'b1;
        state_n    = TXWAIT;
        if (cmd == CH_G) begin
          ret_n = SHIFT;
        end else begin
          idx_n = idx + 16'd1;
          ret_n = last ? IDLE : GETBIT;
        end
      end

      TXWAIT: begin
        if (tx_start) begin
          if (!tx_ready) tx_start_n = 1'b0;
        end else if (tx_ready) begin
          state_n = ret;
          if (ret == SHIFT) begin
            part_se_n = 1'b1;
            part_tm_n = 1'b1;
            flag_n    = 1'b0;
          end
        end
      end

      SHIFT: begin
        // One setup clk with the clock low, then a full high/low part cycle.
        if (part_clk) begin
          part_clk_n = 1'b0;
        end else if (!flag) begin
          part_clk_n = 1'b1;
          flag_n     = 1'b1;
        end else begin
          flag_n    = 1'b0;
          part_se_n = 1'b0;
          idx_n     = idx + 16'd1;
          if (last)             state_n = IDLE;
          else if (cmd == CH_S) state_n = SETBIT;
          else                  state_n = GETBIT;
        end
      end

      EXEC: begin
        if (part_clk) begin
          part_clk_n = 1'b0;
          idx_n      = idx + 16'd1;
        end else if (idx == cnt) begin
          state_n = IDLE;
        end else begin
          part_clk_n = 1'b1;
        end
      end

      FREE: begin
        // 'd' only ends the run at the close of the current part cycle.
        if (part_clk) begin
          part_clk_n = 1'b0;
          if (rx_rcv && rx_data == CH_D) flag_n = 1'b1;
        end else if (flag || (rx_rcv && rx_data == CH_D)) begin
          flag_n  = 1'b0;
          state_n = IDLE;
        end else begin
          part_clk_n = 1'b1;
        end
      end

      default: state_n = INIT;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= INIT;
      ret       <= IDLE;
      cmd       <= '0;
      cnt       <= '0;
      idx       <= '0;
      flag      <= 1'b0;
      po_snap   <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      part_clk  <= 1'b0;
      part_rstn <= 1'b0;
      part_se   <= 1'b0;
      part_tm   <= 1'b0;
      part_si   <= 1'b0;
      part_pi   <= '0;
    end else begin
      state     <= state_n;
      ret       <= ret_n;
      cmd       <= cmd_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      flag      <= flag_n;
      po_snap   <= po_snap_n;
      tx_start  <= tx_start_n;
      tx_data   <= tx_data_n;
      part_clk  <= part_clk_n;
      part_rstn <= part_rstn_n;
      part_se   <= part_se_n;
      part_tm   <= part_tm_n;
      part_si   <= part_si_n;
      part_pi   <= part_pi_n;
    end
  end

endmodule

// File: tb/tb_csoc_cmd_proc.sv
// Directed bench for csoc_cmd_proc: transmit scoreboard, 3-bit loopback scan
// model and part clock edge counters.
module tb_csoc_cmd_proc;
  localparam int PI_W       = 8;
  localparam int PO_W       = 8;
  localparam int RST_CYCLES = 4;

  logic            clk = 1'b0;
  logic            rstn, rx_rcv, tx_start, tx_ready;
  logic            part_clk, part_rstn, part_se, part_tm, part_si, part_so, busy;
  logic [7:0]      rx_data, tx_data;
  logic [PI_W-1:0] part_pi;
  logic [PO_W-1:0] part_po;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         rises    = 0;
  int         se_rises = 0;
  logic [2:0] chain    = '0;

  csoc_cmd_proc #(.PI_W(PI_W), .PO_W(PO_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rstn(rstn), .rx_rcv(rx_rcv), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
    .part_clk(part_clk), .part_rstn(part_rstn), .part_se(part_se),
    .part_tm(part_tm), .part_si(part_si), .part_so(part_so),
    .part_pi(part_pi), .part_po(part_po), .busy(busy)
  );

  always #10 clk = ~clk;

  assign part_so = chain[2];

  // Part-side model: edge counters plus 3-bit scan chain
  always @(posedge part_clk) begin
    rises <= rises + 1;
    if (part_se) begin
      se_rises <= se_rises + 1;
      chain    <= {chain[1:0], part_si};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; consecutive calls give back-to-back pulses
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_rcv  = 1'b1;
    @(negedge clk);
    rx_rcv  = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic wait_for(input string tag, input logic [3:0] s, input int budget);
    int n = 0;
    while (!(4'(dut.state) == s && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(dut.state), 32'(s));
    chk("txq_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Transmitter model: accept on start, hold ready low, check the handshake
  initial begin
    logic [7:0]  got;
    logic [31:0] want;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start && tx_ready) begin
        got      = tx_data;
        tx_ready = 1'b0;
        want     = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
        chk("tx_byte", 32'(got), want);
        repeat (4) @(negedge clk);
        chk("tx_start_drop", {31'b0, tx_start}, 32'd0);
        chk("tx_data_hold", 32'(tx_data), want);
        tx_ready = 1'b1;
      end
    end
  end

  initial begin
    int n, r0, s0;
    rstn = 1'b0; rx_rcv = 1'b0; rx_data = '0; part_po = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({tx_start, tx_data, part_clk, part_rstn, part_se,
                           part_tm, part_si, part_pi, busy}), 32'h1);
    chk("reset_state", 32'(dut.state), 32'd0);

    // Power-on part reset: 8 clk low with 4 part pulses, IDLE on the 9th
    r0 = rises;
    rstn = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!part_rstn) n++;
    end
    chk("prst_state", 32'(dut.state), 32'd8);
    chk("prst_rstn_low_clks", 32'(n), 32'd8);
    @(negedge clk);
    chk("prst_idle", 32'(dut.state), 32'd5);
    chk("prst_rstn_high", {31'b0, part_rstn}, 32'd1);
    chk("prst_busy", {31'b0, busy}, 32'd0);
    chk("prst_rises", 32'(rises - r0), 32'd4);

    // Set inputs, back-to-back bytes
    send("e"); send(8'h00); send(8'h04); send("1"); send("0"); send("1"); send("1");
    wait_for("e_idle", 4'd5, 10);
    chk("e_pi", 32'(part_pi), 32'h0D);
    push_str("!");
    send("e"); send(8'h00); send(8'h02); send("1"); send("x");
    wait_for("e_abort1", 4'd5, 50);
    chk("e_pi_abort1", 32'(part_pi), 32'h0D);
    push_str("!");
    send("e"); send(8'h00); send(8'h03); send("0"); send("y");
    wait_for("e_abort2", 4'd5, 50);
    chk("e_pi_abort2", 32'(part_pi), 32'h0C);
    send("e"); send(8'h00); send(8'h0A);
    for (int i = 0; i < 10; i++) send("1");
    wait_for("e_wide", 4'd5, 10);
    chk("e_pi_wide", 32'(part_pi), 32'hFF);

    // Get outputs, snapshot taken when the count completes
    part_po = 8'hA9;
    push_str("10010101000");
    send("i"); send(8'h00); send(8'h0B);
    part_po = 8'h00;
    wait_for("i_done", 4'd5, 400);

    // Set state through the loopback chain
    s0 = se_rises;
    send("s"); send(8'h00); send(8'h03);
    send("1"); wait_for("s_bit0", 4'd3, 20);
    send("0"); wait_for("s_bit1", 4'd3, 20);
    send("1"); wait_for("s_done", 4'd5, 20);
    chk("s_shifts", 32'(se_rises - s0), 32'd3);
    chk("s_chain", 32'(chain), 32'h5);
    chk("s_se_low", {31'b0, part_se}, 32'd0);
    chk("s_tm_held", {31'b0, part_tm}, 32'd1);

    // Get state
    s0 = se_rises;
    push_str("101");
    send("g"); send(8'h00); send(8'h03);
    wait_for("g_done", 4'd5, 200);
    chk("g_shifts", 32'(se_rises - s0), 32'd3);
    chk("g_se_low", {31'b0, part_se}, 32'd0);
    chk("g_tm_held", {31'b0, part_tm}, 32'd1);

    // Execute 10 part cycles
    r0 = rises; s0 = se_rises;
    send("o"); send(8'h00); send(8'h0A);
    n = 0;
    while (dut.state != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("o_clks_to_idle", 32'(n), 32'd21);
    chk("o_rises", 32'(rises - r0), 32'd10);
    chk("o_se_rises", 32'(se_rises - s0), 32'd0);
    chk("o_tm_low", {31'b0, part_tm}, 32'd0);
    chk("o_clk_low", {31'b0, part_clk}, 32'd0);

    // Free run; a stray byte is dropped, 'd' stops with the clock low
    r0 = rises;
    send("f"); send("z");
    #1000;
    @(negedge clk);
    send("d");
    wait_for("f_stop", 4'd5, 10);
    chk("f_clk_low", {31'b0, part_clk}, 32'd0);
    chk("f_ran", {31'b0, (rises - r0) >= 20}, 32'd1);

    // 'd' in IDLE is ignored, unknown command answers '?'
    send("d");
    repeat (3) @(negedge clk);
    chk("d_idle", 32'(dut.state), 32'd5);
    push_str("?");
    send("z");
    wait_for("q_resp", 4'd5, 30);

    // Reset in the middle of a long execute
    send("o"); send(8'hFF); send(8'hFF);
    repeat (20) @(negedge clk);
    chk("o_long_exec", 32'(dut.state), 32'd6);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_outs", 32'({tx_start, tx_data, part_clk, part_rstn, part_se,
                            part_tm, part_si, part_pi, busy}), 32'h1);
    chk("midrst_state", 32'(dut.state), 32'd0);
    rstn = 1'b1;
    n = 0;
    while (dut.state != 4'd5 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_clks_to_idle", 32'(n), 32'd9);
    chk("final_txq", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
